// File: rtl/bp_pkg.sv
// Shared types and constants for the branch resolve unit and its in-flight queue.
package bp_pkg;

    localparam int unsigned BP_ADDR_W      = 32;
    localparam int unsigned BP_BTB_ENTRIES = 16;
    localparam int unsigned BP_QDEPTH      = 4;
    localparam int unsigned BP_IDX_W       = $clog2(BP_BTB_ENTRIES);
    localparam int unsigned BP_TAG_W       = BP_ADDR_W - BP_IDX_W;

    localparam logic [1:0] CTR_WEAK_NT = 2'b01;
    localparam logic [1:0] CTR_WEAK_T  = 2'b10;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0]  tag;
        logic [BP_ADDR_W-1:0] target;
        logic [1:0]           ctr;
    } btb_entry_t;

    typedef struct packed {
        logic [BP_ADDR_W-1:0] pc;
        logic                 pred_taken;
        logic [BP_ADDR_W-1:0] pred_target;
    } inflight_t;

    typedef enum logic {
        RUN,
        FLUSH
    } bru_state_e;

    // Two-bit saturating counter step; never wraps.
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of outstanding predictions; clear empties it in one cycle.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  inflight_t        wdata,
    output inflight_t        rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    inflight_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
            if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// BTB-based branch predictor with in-order resolution and one-cycle redirect flush.
// Optional statistics counters are enabled by defining BP_STATS_EN.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = BP_BTB_ENTRIES,
    parameter int unsigned ADDR_W      = BP_ADDR_W,
    parameter int unsigned QDEPTH      = BP_QDEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              prediction,
    output logic [ADDR_W-1:0] BTB_address,
    output logic              stall_fetch,
    input  logic              resolve_valid,
    input  logic              resolve_is_br,
    input  logic              resolve_taken,
    input  logic [ADDR_W-1:0] resolve_target,
    output logic              flush_pipeline,
    output logic [ADDR_W-1:0] true_address,
    output logic              protocol_err,
    output logic [15:0]       stat_branches,
    output logic [15:0]       stat_mispredicts
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

    btb_entry_t        btb_q [BTB_ENTRIES];
    bru_state_e        state_q, state_d;
    logic              flush_q, flush_d;
    logic [ADDR_W-1:0] true_q, true_d;
    logic              err_q, err_d;

    // Fetch-side lookup
    logic [IDX_W-1:0]  f_idx;
    btb_entry_t        f_ent;
    logic              f_hit;

    assign f_idx       = fetch_pc[IDX_W-1:0];
    assign f_ent       = btb_q[f_idx];
    assign f_hit       = f_ent.valid && (f_ent.tag == fetch_pc[ADDR_W-1:IDX_W]);
    assign prediction  = fetch_valid & f_hit & f_ent.ctr[1] & (state_q == RUN);
    assign BTB_address = f_hit ? f_ent.target : '0;

    // In-flight queue
    logic              q_push, q_pop, q_full, q_empty, q_clear;
    logic [CNT_W-1:0]  q_count;
    inflight_t         q_wdata, head;

    assign q_wdata.pc          = fetch_pc;
    assign q_wdata.pred_taken  = prediction;
    assign q_wdata.pred_target = BTB_address;
    assign q_push      = fetch_valid & ~q_full & (state_q == RUN);
    assign q_pop       = resolve_valid & (q_count != '0) & (state_q == RUN);
    assign stall_fetch = q_full;

    bp_inflight_fifo #(
        .DEPTH (QDEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (q_clear),
        .push  (q_push),
        .pop   (q_pop),
        .wdata (q_wdata),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // Resolution compare; a non-branch predicted taken is also a mispredict
    logic              mispredict;
    logic [ADDR_W-1:0] redirect;

    always_comb begin
        mispredict = 1'b0;
        if (q_pop) begin
            if (resolve_is_br) begin
                mispredict = (head.pred_taken != resolve_taken) ||
                             (resolve_taken && (head.pred_target != resolve_target));
            end else begin
                mispredict = head.pred_taken;
            end
        end
    end

    assign redirect = (resolve_is_br && resolve_taken) ? resolve_target
                                                       : head.pc + ADDR_W'(1);
    assign q_clear  = mispredict;

    always_comb begin
        state_d = state_q;
        flush_d = 1'b0;
        true_d  = true_q;
        err_d   = err_q | (resolve_valid & q_empty & (state_q == RUN));
        unique case (state_q)
            RUN: begin
                if (mispredict) begin
                    state_d = FLUSH;
                    flush_d = 1'b1;
                    true_d  = redirect;
                end
            end
            FLUSH: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            flush_q <= 1'b0;
            true_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            true_q  <= true_d;
            err_q   <= err_d;
        end
    end

    assign flush_pipeline = flush_q;
    assign true_address   = true_q;
    assign protocol_err   = err_q;

    // BTB training on a popped branch
    logic [IDX_W-1:0]  r_idx;
    btb_entry_t        r_ent, upd_ent;
    logic              r_hit, upd_en;

    assign r_idx = head.pc[IDX_W-1:0];
    assign r_ent = btb_q[r_idx];
    assign r_hit = r_ent.valid && (r_ent.tag == head.pc[ADDR_W-1:IDX_W]);

    always_comb begin
        upd_ent = r_ent;
        upd_en  = 1'b0;
        if (q_pop && resolve_is_br) begin
            if (r_hit) begin
                upd_en      = 1'b1;
                upd_ent.ctr = ctr_update(r_ent.ctr, resolve_taken);
                if (resolve_taken) upd_ent.target = resolve_target;
            end else if (resolve_taken) begin
                upd_en         = 1'b1;
                upd_ent.valid  = 1'b1;
                upd_ent.tag    = head.pc[ADDR_W-1:IDX_W];
                upd_ent.target = resolve_target;
                upd_ent.ctr    = CTR_WEAK_T;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
            end
        end else if (upd_en) begin
            btb_q[r_idx] <= upd_ent;
        end
    end

`ifdef BP_STATS_EN
    logic [15:0] st_br_q, st_mp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_br_q <= '0;
            st_mp_q <= '0;
        end else begin
            if (q_pop && resolve_is_br && (st_br_q != 16'hFFFF)) st_br_q <= st_br_q + 16'd1;
            if (mispredict && (st_mp_q != 16'hFFFF))             st_mp_q <= st_mp_q + 16'd1;
        end
    end

    assign stat_branches    = st_br_q;
    assign stat_mispredicts = st_mp_q;
`else
    assign stat_branches    = 16'h0;
    assign stat_mispredicts = 16'h0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (default build, stats disabled).
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        prediction;
    logic [31:0] BTB_address;
    logic        stall_fetch;
    logic        resolve_valid;
    logic        resolve_is_br;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        flush_pipeline;
    logic [31:0] true_address;
    logic        protocol_err;
    logic [15:0] stat_branches;
    logic [15:0] stat_mispredicts;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_valid      (fetch_valid),
        .fetch_pc         (fetch_pc),
        .prediction       (prediction),
        .BTB_address      (BTB_address),
        .stall_fetch      (stall_fetch),
        .resolve_valid    (resolve_valid),
        .resolve_is_br    (resolve_is_br),
        .resolve_taken    (resolve_taken),
        .resolve_target   (resolve_target),
        .flush_pipeline   (flush_pipeline),
        .true_address     (true_address),
        .protocol_err     (protocol_err),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        #1;
    endtask

    task automatic resolve(input logic is_br, input logic taken, input logic [31:0] tgt);
        resolve_valid  = 1'b1;
        resolve_is_br  = is_br;
        resolve_taken  = taken;
        resolve_target = tgt;
    endtask

    task automatic quiet();
        fetch_valid   = 1'b0;
        resolve_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_valid = 1'b0; fetch_pc = '0;
        resolve_valid = 1'b0; resolve_is_br = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
        #12 rst_n = 1'b1;
        #1;
        check("rst_pred", prediction, 0);
        check("rst_btb_addr", BTB_address, 0);
        check("rst_stall", stall_fetch, 0);
        check("rst_flush", flush_pipeline, 0);
        check("rst_true_addr", true_address, 0);
        check("rst_perr", protocol_err, 0);
        check("rst_stat_br", stat_branches, 0);
        check("rst_stat_mp", stat_mispredicts, 0);

        // Cold miss at pc 5, resolves taken to 12
        fetch(32'd5);
        check("cold_pred", prediction, 0);
        check("cold_btb_addr", BTB_address, 0);
        tick(); quiet();
        resolve(1'b1, 1'b1, 32'd12);
        tick(); quiet();
        check("cold_flush", flush_pipeline, 1);
        check("cold_true_addr", true_address, 12);
        tick();
        check("cold_flush_end", flush_pipeline, 0);

        // Warm hit, ctr 10 -> 11
        fetch(32'd5);
        check("warm_pred", prediction, 1);
        check("warm_btb_addr", BTB_address, 12);
        tick(); quiet();
        resolve(1'b1, 1'b1, 32'd12);
        tick(); quiet();
        check("warm_no_flush", flush_pipeline, 0);

        // Not taken #1: ctr 11 -> 10, predicted taken so redirect to pc+1
        fetch(32'd5);
        check("nt1_pred", prediction, 1);
        tick(); quiet();
        resolve(1'b1, 1'b0, 32'd0);
        tick(); quiet();
        check("nt1_flush", flush_pipeline, 1);
        check("nt1_true_addr", true_address, 6);
        tick();

        // Not taken #2: ctr 10 still predicts taken -> redirect, ctr 10 -> 01
        fetch(32'd5);
        check("nt2_pred", prediction, 1);
        tick(); quiet();
        resolve(1'b1, 1'b0, 32'd0);
        tick(); quiet();
        check("nt2_flush", flush_pipeline, 1);
        check("nt2_true_addr", true_address, 6);
        tick();

        // Not taken #3: ctr 01 predicts not taken -> correct, ctr 01 -> 00
        fetch(32'd5);
        check("nt3_pred", prediction, 0);
        check("nt3_btb_addr", BTB_address, 12);
        tick(); quiet();
        resolve(1'b1, 1'b0, 32'd0);
        tick(); quiet();
        check("nt3_no_flush", flush_pipeline, 0);

        // Taken #1: ctr 00 -> 01
        fetch(32'd5);
        check("t1_pred", prediction, 0);
        tick(); quiet();
        resolve(1'b1, 1'b1, 32'd12);
        tick(); quiet();
        check("t1_flush", flush_pipeline, 1);
        check("t1_true_addr", true_address, 12);
        tick();

        // Taken #2: ctr 01 -> 10
        fetch(32'd5);
        check("t2_pred", prediction, 0);
        tick(); quiet();
        resolve(1'b1, 1'b1, 32'd12);
        tick(); quiet();
        check("t2_flush", flush_pipeline, 1);
        tick();
        fetch(32'd5);
        check("t2_ctr_weak_t", prediction, 1);
        quiet();

        // Fill the queue with misses at pcs 100..103
        for (int i = 0; i < 4; i++) begin
            fetch(32'd100 + 32'(i));
            check("fill_stall_low", stall_fetch, 0);
            tick();
        end
        fetch(32'd104);
        check("fill_stall_high", stall_fetch, 1);
        tick(); quiet();
        check("drop_stall_held", stall_fetch, 1);
        resolve(1'b0, 1'b0, 32'd0);
        tick(); quiet();
        check("pop_stall_low", stall_fetch, 0);
        check("pop_no_flush", flush_pipeline, 0);
        // Push and pop together at count 3
        fetch(32'd105);
        resolve(1'b0, 1'b0, 32'd0);
        tick(); quiet();
        check("pushpop_count_same", stall_fetch, 0);
        check("pushpop_no_flush", flush_pipeline, 0);
        fetch(32'd106);
        tick(); quiet();
        check("refill_stall", stall_fetch, 1);

        // Head (pc 102, predicted not taken) resolves taken with 3 younger entries behind it
        resolve(1'b1, 1'b1, 32'd200);
        tick(); quiet();
        check("qflush_flush", flush_pipeline, 1);
        check("qflush_true_addr", true_address, 200);
        check("qflush_stall", stall_fetch, 0);
        // Activity during the FLUSH cycle is ignored
        resolve(1'b0, 1'b0, 32'd0);
        fetch(32'd5);
        check("flush_pred_forced", prediction, 0);
        tick(); quiet();
        check("flush_resolve_no_perr", protocol_err, 0);
        check("flush_end", flush_pipeline, 0);

        // Queue is empty now
        resolve(1'b1, 1'b1, 32'd0);
        tick(); quiet();
        check("perr_set", protocol_err, 1);
        check("perr_no_flush", flush_pipeline, 0);
        tick();
        check("perr_sticky", protocol_err, 1);

        // pc+1 wrap: allocate at all-ones pc, then a predicted-taken non-branch
        fetch(32'hFFFF_FFFF);
        tick(); quiet();
        resolve(1'b1, 1'b1, 32'd40);
        tick(); quiet();
        check("wrap_alloc_flush", flush_pipeline, 1);
        check("wrap_alloc_true", true_address, 40);
        tick();
        fetch(32'hFFFF_FFFF);
        check("wrap_pred", prediction, 1);
        check("wrap_btb_addr", BTB_address, 40);
        tick(); quiet();
        resolve(1'b0, 1'b0, 32'd0);
        tick(); quiet();
        check("nonbr_flush", flush_pipeline, 1);
        check("nonbr_true_wrap", true_address, 0);
        tick();

        // Async reset during a flush pulse
        fetch(32'd7);
        tick(); quiet();
        resolve(1'b1, 1'b1, 32'd300);
        tick(); quiet();
        check("pre_rst_flush", flush_pipeline, 1);
        check("pre_rst_true", true_address, 300);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_flush", flush_pipeline, 0);
        check("async_rst_true", true_address, 0);
        check("async_rst_perr", protocol_err, 0);
        fetch(32'd5);
        check("async_rst_pred", prediction, 0);
        check("async_rst_btb_addr", BTB_address, 0);
        quiet();
        #5 rst_n = 1'b1;
        tick();
        check("post_rst_flush", flush_pipeline, 0);
        check("stats_off_br", stat_branches, 0);
        check("stats_off_mp", stat_mispredicts, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
